// File: rtl/sram_port_arbiter.sv
// Round-robin arbiter sharing one single-port SRAM between a write engine and a read engine.
// Each grant covers a whole multi-beat transaction; read data returns one cycle after its beat.
module sram_port_arbiter #(
   parameter int unsigned SRAM_ADDR_WIDTH = 8,
   parameter int unsigned SRAM_DATA_WIDTH = 8,
   parameter int unsigned MAX_BEATS       = 8,
   parameter int unsigned LEN_WIDTH       = $clog2(MAX_BEATS + 1)
) (
   input  logic                       clk,
   input  logic                       reset,
   // write engine
   input  logic                       wr_req_i,
   input  logic [LEN_WIDTH-1:0]       wr_len_i,
   output logic                       wr_gnt_o,
   input  logic                       wr_beat_valid_i,
   input  logic [SRAM_ADDR_WIDTH-1:0] wr_addr_i,
   input  logic [SRAM_DATA_WIDTH-1:0] wr_data_i,
   output logic                       wr_beat_ready_o,
   output logic                       wr_done_o,
   // read engine
   input  logic                       rd_req_i,
   input  logic [LEN_WIDTH-1:0]       rd_len_i,
   output logic                       rd_gnt_o,
   input  logic                       rd_beat_valid_i,
   input  logic [SRAM_ADDR_WIDTH-1:0] rd_addr_i,
   output logic                       rd_beat_ready_o,
   output logic [SRAM_DATA_WIDTH-1:0] rd_data_o,
   output logic                       rd_data_valid_o,
   output logic                       rd_done_o,
   // SRAM pins
   output logic                       sram_chip_en_o,
   output logic                       sram_wr_en_o,
   output logic                       sram_rd_en_o,
   output logic [SRAM_ADDR_WIDTH-1:0] sram_addr_o,
   output logic [SRAM_DATA_WIDTH-1:0] sram_wr_data_o,
   input  logic [SRAM_DATA_WIDTH-1:0] sram_rd_data_i
);

   localparam logic [LEN_WIDTH-1:0] MaxLen = LEN_WIDTH'(MAX_BEATS);
   localparam logic [LEN_WIDTH-1:0] OneLen = LEN_WIDTH'(1);

   typedef enum logic [1:0] {StIdle, StWrBurst, StRdBurst, StRdDrain} state_e;

   state_e               state_q;
   logic [LEN_WIDTH-1:0] cnt_q;
   logic                 prio_rd_q;   // 1: read wins the next tie
   logic                 wr_done_q;
   logic                 rd_done_q;
   logic                 rd_valid_q;

   logic wr_accept;
   logic rd_accept;
   logic last_beat;

   function automatic logic [LEN_WIDTH-1:0] clamp_len(input logic [LEN_WIDTH-1:0] len);
      if (len == '0) begin
         return OneLen;
      end else if (len > MaxLen) begin
         return MaxLen;
      end else begin
         return len;
      end
   endfunction

   assign wr_gnt_o        = (state_q == StWrBurst);
   assign rd_gnt_o        = (state_q == StRdBurst) || (state_q == StRdDrain);
   assign wr_beat_ready_o = (state_q == StWrBurst);
   assign rd_beat_ready_o = (state_q == StRdBurst);

   assign wr_accept = wr_beat_ready_o && wr_beat_valid_i;
   assign rd_accept = rd_beat_ready_o && rd_beat_valid_i;
   assign last_beat = (cnt_q <= OneLen);

   assign wr_done_o       = wr_done_q;
   assign rd_done_o       = rd_done_q;
   assign rd_data_valid_o = rd_valid_q;
   assign rd_data_o       = rd_valid_q ? sram_rd_data_i : '0;

   // SRAM pins are driven only in the cycle a beat is accepted, otherwise held at zero.
   always_comb begin
      sram_chip_en_o = 1'b0;
      sram_wr_en_o   = 1'b0;
      sram_rd_en_o   = 1'b0;
      sram_addr_o    = '0;
      sram_wr_data_o = '0;
      if (wr_accept) begin
         sram_chip_en_o = 1'b1;
         sram_wr_en_o   = 1'b1;
         sram_addr_o    = wr_addr_i;
         sram_wr_data_o = wr_data_i;
      end else if (rd_accept) begin
         sram_chip_en_o = 1'b1;
         sram_rd_en_o   = 1'b1;
         sram_addr_o    = rd_addr_i;
      end
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state_q    <= StIdle;
         cnt_q      <= '0;
         prio_rd_q  <= 1'b0;
         wr_done_q  <= 1'b0;
         rd_done_q  <= 1'b0;
         rd_valid_q <= 1'b0;
      end else begin
         wr_done_q  <= 1'b0;
         rd_done_q  <= 1'b0;
         rd_valid_q <= rd_accept;

         if ((wr_accept || rd_accept) && (cnt_q != '0)) begin
            cnt_q <= cnt_q - OneLen;
         end

         unique case (state_q)
            StIdle: begin
               if (wr_req_i && (!rd_req_i || !prio_rd_q)) begin
                  state_q   <= StWrBurst;
                  cnt_q     <= clamp_len(wr_len_i);
                  prio_rd_q <= 1'b1;
               end else if (rd_req_i) begin
                  state_q   <= StRdBurst;
                  cnt_q     <= clamp_len(rd_len_i);
                  prio_rd_q <= 1'b0;
               end
            end
            StWrBurst: begin
               if (wr_accept && last_beat) begin
                  state_q   <= StIdle;
                  wr_done_q <= 1'b1;
               end
            end
            StRdBurst: begin
               // Done is raised with the last beat so it lines up with the last returned data.
               if (rd_accept && last_beat) begin
                  state_q   <= StRdDrain;
                  rd_done_q <= 1'b1;
               end
            end
            StRdDrain: begin
               state_q <= StIdle;
            end
            default: begin
               state_q <= StIdle;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_sram_port_arbiter.sv
// Directed bench for sram_port_arbiter with a behavioural single-port SRAM behind it.
module tb_sram_port_arbiter;

   logic       clk;
   logic       reset;
   logic       wr_req_i, wr_gnt_o, wr_beat_valid_i, wr_beat_ready_o, wr_done_o;
   logic [3:0] wr_len_i, rd_len_i;
   logic [7:0] wr_addr_i, wr_data_i, rd_addr_i, rd_data_o;
   logic       rd_req_i, rd_gnt_o, rd_beat_valid_i, rd_beat_ready_o, rd_data_valid_o, rd_done_o;
   logic       sram_chip_en_o, sram_wr_en_o, sram_rd_en_o;
   logic [7:0] sram_addr_o, sram_wr_data_o, sram_rd_data_i;

   int checks = 0;
   int errors = 0;
   int beats;

   logic [33:0] all_out;
   assign all_out = {wr_gnt_o, wr_beat_ready_o, wr_done_o, rd_gnt_o, rd_beat_ready_o, rd_data_o,
                     rd_data_valid_o, rd_done_o, sram_chip_en_o, sram_wr_en_o, sram_rd_en_o,
                     sram_addr_o, sram_wr_data_o};

   sram_port_arbiter #(
      .SRAM_ADDR_WIDTH(8),
      .SRAM_DATA_WIDTH(8),
      .MAX_BEATS      (8),
      .LEN_WIDTH      (4)
   ) dut (
      .clk             (clk),
      .reset           (reset),
      .wr_req_i        (wr_req_i),
      .wr_len_i        (wr_len_i),
      .wr_gnt_o        (wr_gnt_o),
      .wr_beat_valid_i (wr_beat_valid_i),
      .wr_addr_i       (wr_addr_i),
      .wr_data_i       (wr_data_i),
      .wr_beat_ready_o (wr_beat_ready_o),
      .wr_done_o       (wr_done_o),
      .rd_req_i        (rd_req_i),
      .rd_len_i        (rd_len_i),
      .rd_gnt_o        (rd_gnt_o),
      .rd_beat_valid_i (rd_beat_valid_i),
      .rd_addr_i       (rd_addr_i),
      .rd_beat_ready_o (rd_beat_ready_o),
      .rd_data_o       (rd_data_o),
      .rd_data_valid_o (rd_data_valid_o),
      .rd_done_o       (rd_done_o),
      .sram_chip_en_o  (sram_chip_en_o),
      .sram_wr_en_o    (sram_wr_en_o),
      .sram_rd_en_o    (sram_rd_en_o),
      .sram_addr_o     (sram_addr_o),
      .sram_wr_data_o  (sram_wr_data_o),
      .sram_rd_data_i  (sram_rd_data_i)
   );

   // SRAM cell: read data appears one cycle after the read strobe.
   logic [7:0] mem [256];
   logic [7:0] mem_rd_q;
   always_ff @(posedge clk) begin
      if (sram_chip_en_o && sram_wr_en_o) mem[sram_addr_o] <= sram_wr_data_o;
      if (sram_chip_en_o && sram_rd_en_o) mem_rd_q <= mem[sram_addr_o];
   end
   assign sram_rd_data_i = mem_rd_q;

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic wr_burst_beats(input logic [3:0] len, output int n);
      n = 0;
      wr_req_i = 1; wr_len_i = len; wr_beat_valid_i = 1; wr_addr_i = 8'h40; wr_data_i = 8'h11;
      tick();
      wr_req_i = 0;
      for (int c = 0; c < 12; c++) begin
         #1;
         if (sram_chip_en_o && sram_wr_en_o) n++;
         tick();
      end
      wr_beat_valid_i = 0;
   endtask

   bit ew  [14] = '{0, 1, 1, 0, 0, 0, 0, 0, 1, 1, 0, 0, 0, 0};
   bit er  [14] = '{0, 0, 0, 0, 1, 1, 1, 0, 0, 0, 0, 1, 1, 1};
   bit ewd [14] = '{0, 0, 0, 1, 0, 0, 0, 0, 0, 0, 1, 0, 0, 0};
   bit erd [14] = '{0, 0, 0, 0, 0, 0, 1, 0, 0, 0, 0, 0, 0, 1};

   initial begin
      reset = 0;
      wr_req_i = 0; wr_len_i = 0; wr_beat_valid_i = 0; wr_addr_i = 0; wr_data_i = 0;
      rd_req_i = 0; rd_len_i = 0; rd_beat_valid_i = 0; rd_addr_i = 0;
      #2;
      chk("reset_outputs", all_out, 0);
      tick(); tick();
      reset = 1;
      tick(); #1;
      chk("idle_no_gnt", {wr_gnt_o, rd_gnt_o}, 0);
      chk("idle_no_strobe", {sram_chip_en_o, sram_wr_en_o, sram_rd_en_o}, 0);

      // Single 3-beat write.
      wr_req_i = 1; wr_len_i = 3; wr_beat_valid_i = 1; wr_addr_i = 8'h10; wr_data_i = 8'hA1;
      #1;
      chk("wr_pre_grant_no_strobe", sram_chip_en_o, 0);
      for (int i = 0; i < 3; i++) begin
         tick();
         wr_req_i = 0; wr_addr_i = 8'(16 + i); wr_data_i = 8'(8'hA1 + i);
         #1;
         chk("wr_gnt", wr_gnt_o, 1);
         chk("wr_strobe", {sram_chip_en_o, sram_wr_en_o, sram_rd_en_o}, 3'b110);
         chk("wr_addr", sram_addr_o, 8'(16 + i));
         chk("wr_data", sram_wr_data_o, 8'(8'hA1 + i));
         chk("wr_done_early", wr_done_o, 0);
      end
      tick();
      wr_beat_valid_i = 0;
      #1;
      chk("wr_done", wr_done_o, 1);
      chk("wr_gnt_released", wr_gnt_o, 0);
      chk("wr_done_no_strobe", sram_chip_en_o, 0);
      tick(); #1;
      chk("wr_done_pulse", wr_done_o, 0);

      // Preload 0x20..0x23 with 0x5A..0x5D.
      wr_req_i = 1; wr_len_i = 4; wr_beat_valid_i = 1; wr_addr_i = 8'h20; wr_data_i = 8'h5A;
      tick();
      wr_req_i = 0;
      for (int i = 1; i < 4; i++) begin
         tick();
         wr_addr_i = 8'(32 + i); wr_data_i = 8'(8'h5A + i);
      end
      tick();
      wr_beat_valid_i = 0;
      tick();

      // Single 4-beat read.
      rd_req_i = 1; rd_len_i = 4; rd_beat_valid_i = 1; rd_addr_i = 8'h20;
      tick();
      rd_req_i = 0;
      #1;
      chk("rd_gnt", rd_gnt_o, 1);
      chk("rd_strobe", {sram_chip_en_o, sram_wr_en_o, sram_rd_en_o}, 3'b101);
      chk("rd_addr", sram_addr_o, 8'h20);
      chk("rd_valid_first", rd_data_valid_o, 0);
      for (int i = 1; i < 4; i++) begin
         tick();
         rd_addr_i = 8'(32 + i);
         #1;
         chk("rd_strobe", {sram_chip_en_o, sram_wr_en_o, sram_rd_en_o}, 3'b101);
         chk("rd_addr", sram_addr_o, 8'(32 + i));
         chk("rd_valid", rd_data_valid_o, 1);
         chk("rd_data", rd_data_o, 8'(8'h5A + i - 1));
         chk("rd_done_early", rd_done_o, 0);
      end
      tick();
      rd_beat_valid_i = 0;
      #1;
      chk("rd_last_valid", rd_data_valid_o, 1);
      chk("rd_last_data", rd_data_o, 8'h5D);
      chk("rd_done", rd_done_o, 1);
      chk("rd_drain_gnt", rd_gnt_o, 1);
      chk("rd_drain_no_strobe", sram_chip_en_o, 0);
      tick(); #1;
      chk("rd_idle_gnt", rd_gnt_o, 0);
      chk("rd_idle_valid", {rd_data_valid_o, rd_done_o, rd_data_o}, 0);

      // Both requesters held: grants alternate W, R, W, R.
      wr_req_i = 1; rd_req_i = 1; wr_len_i = 2; rd_len_i = 2;
      wr_beat_valid_i = 1; rd_beat_valid_i = 1;
      wr_addr_i = 8'h30; wr_data_i = 8'h77; rd_addr_i = 8'h31;
      for (int c = 0; c < 14; c++) begin
         #1;
         chk($sformatf("rr_wr_gnt_c%0d", c), wr_gnt_o, 64'(ew[c]));
         chk($sformatf("rr_rd_gnt_c%0d", c), rd_gnt_o, 64'(er[c]));
         chk($sformatf("rr_wr_done_c%0d", c), wr_done_o, 64'(ewd[c]));
         chk($sformatf("rr_rd_done_c%0d", c), rd_done_o, 64'(erd[c]));
         chk("rr_exclusive_strobes", sram_wr_en_o && sram_rd_en_o, 0);
         if (c == 13) begin
            wr_req_i = 0; rd_req_i = 0;
         end
         tick();
      end
      wr_beat_valid_i = 0; rd_beat_valid_i = 0;
      tick();

      // Length edges.
      wr_burst_beats(4'd0, beats);
      chk("len0_beats", beats, 1);
      wr_burst_beats(4'd15, beats);
      chk("len15_beats", beats, 8);

      // Stall mid-burst.
      wr_req_i = 1; wr_len_i = 3; wr_beat_valid_i = 1; wr_addr_i = 8'h50; wr_data_i = 8'h99;
      tick();
      wr_req_i = 0;
      #1;
      chk("stall_first_beat", {sram_chip_en_o, sram_wr_en_o}, 2'b11);
      tick();
      wr_beat_valid_i = 0;
      for (int c = 0; c < 5; c++) begin
         #1;
         chk("stall_gnt_held", wr_gnt_o, 1);
         chk("stall_no_strobe", {sram_chip_en_o, sram_wr_en_o, sram_rd_en_o}, 0);
         tick();
      end
      wr_beat_valid_i = 1;
      beats = 0;
      for (int c = 0; c < 6; c++) begin
         #1;
         if (sram_wr_en_o) beats++;
         tick();
      end
      wr_beat_valid_i = 0;
      chk("stall_remaining_beats", beats, 2);

      // Reset mid write burst, then the pointer must favour write again.
      wr_req_i = 1; wr_len_i = 4; wr_beat_valid_i = 1;
      tick();
      wr_req_i = 0;
      #1;
      chk("mid_wr_active", sram_wr_en_o, 1);
      reset = 0;
      #1;
      chk("mid_wr_reset_outputs", all_out, 0);
      tick();
      reset = 1; wr_beat_valid_i = 0;
      tick(); #1;
      chk("post_reset_idle", {wr_gnt_o, rd_gnt_o, sram_chip_en_o}, 0);
      wr_req_i = 1; rd_req_i = 1; wr_len_i = 1; rd_len_i = 1;
      tick();
      wr_req_i = 0; rd_req_i = 0;
      #1;
      chk("post_reset_wr_first", {wr_gnt_o, rd_gnt_o}, 2'b10);
      wr_beat_valid_i = 1;
      tick();
      wr_beat_valid_i = 0;
      tick();

      // Reset while in read drain discards the returning beat.
      rd_req_i = 1; rd_len_i = 1; rd_beat_valid_i = 1; rd_addr_i = 8'h22;
      tick();
      rd_req_i = 0;
      #1;
      chk("drain_rd_beat", sram_rd_en_o, 1);
      tick();
      rd_beat_valid_i = 0;
      reset = 0;
      #1;
      chk("drain_reset_no_valid", {rd_data_valid_o, rd_done_o, rd_gnt_o}, 0);
      tick();
      reset = 1;
      #1;
      chk("drain_reset_still_no_valid", {rd_data_valid_o, rd_done_o}, 0);
      wr_req_i = 1; rd_req_i = 1; wr_len_i = 1; rd_len_i = 1;
      tick();
      wr_req_i = 0; rd_req_i = 0;
      #1;
      chk("drain_reset_wr_first", {wr_gnt_o, rd_gnt_o}, 2'b10);
      tick();

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
